// File: rtl/pipelined_permutation_network.sv
// Two-stage deflection permutation network for a bufferless router: four flits in,
// four flits out, conflicts resolved by golden flag, then sequence, then a per-block toggle.

module ppn_arb2 #(
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned GOLD_BIT = 0,
  parameter int unsigned SEQ_LSB  = 15,
  parameter int unsigned SEQ_W    = 5
) (
  input  logic [FLIT_W-1:0] flit0,
  input  logic [FLIT_W-1:0] flit1,
  input  logic              vld0,
  input  logic              vld1,
  input  logic              defl0,
  input  logic              defl1,
  input  logic              want0,
  input  logic              want1,
  input  logic              tgl,
  output logic [FLIT_W-1:0] res_flit0_c,
  output logic [FLIT_W-1:0] res_flit1_c,
  output logic              res_vld0_c,
  output logic              res_vld1_c,
  output logic              res_defl0_c,
  output logic              res_defl1_c,
  output logic              tie_c
);
  logic             conflict;
  logic             win0;
  logic             port0;
  logic             port1;
  logic [SEQ_W-1:0] seq0;
  logic [SEQ_W-1:0] seq1;

  // want=1 means the flit asks for out1; the loser of a conflict takes the other port
  always_comb begin
    res_flit0_c = '0;
    res_flit1_c = '0;
    res_vld0_c  = 1'b0;
    res_vld1_c  = 1'b0;
    res_defl0_c = 1'b0;
    res_defl1_c = 1'b0;
    tie_c       = 1'b0;
    win0        = 1'b1;
    seq0        = flit0[SEQ_LSB +: SEQ_W];
    seq1        = flit1[SEQ_LSB +: SEQ_W];
    conflict    = vld0 & vld1 & (want0 == want1);
    if (flit0[GOLD_BIT] != flit1[GOLD_BIT]) begin
      win0 = flit0[GOLD_BIT];
    end else if (seq0 != seq1) begin
      win0 = (seq0 < seq1);
    end else begin
      win0  = ~tgl;
      tie_c = conflict;
    end
    port0 = want0;
    port1 = want1;
    if (conflict) begin
      if (win0) port1 = ~want1;
      else      port0 = ~want0;
    end
    if (vld0) begin
      if (port0) begin
        res_flit1_c = flit0;
        res_vld1_c  = 1'b1;
        res_defl1_c = defl0 | (conflict & ~win0);
      end else begin
        res_flit0_c = flit0;
        res_vld0_c  = 1'b1;
        res_defl0_c = defl0 | (conflict & ~win0);
      end
    end
    if (vld1) begin
      if (port1) begin
        res_flit1_c = flit1;
        res_vld1_c  = 1'b1;
        res_defl1_c = defl1 | (conflict & win0);
      end else begin
        res_flit0_c = flit1;
        res_vld0_c  = 1'b1;
        res_defl0_c = defl1 | (conflict & win0);
      end
    end
  end
endmodule

module pipelined_permutation_network #(
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned GOLD_BIT = 0,
  parameter int unsigned DIR_LSB  = 4,
  parameter int unsigned SEQ_LSB  = 15,
  parameter int unsigned SEQ_W    = 5,
  parameter int unsigned PIPE     = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*FLIT_W-1:0]   in_flit,
  input  logic [3:0]            in_vld,
  input  logic                  cnt_clr,
  output logic [4*FLIT_W-1:0]   out_flit,
  output logic [3:0]            out_vld,
  output logic [3:0]            out_defl,
  output logic [CNT_W-1:0]      defl_cnt
);
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [FLIT_W-1:0] in_f [4];
  logic [FLIT_W-1:0] s1_flit [4];
  logic [3:0]        s1_vld;
  logic [3:0]        s1_defl;
  logic [1:0]        s1_tie;
  logic [FLIT_W-1:0] m_flit [4];
  logic [3:0]        m_vld;
  logic [3:0]        m_defl;
  logic [FLIT_W-1:0] nxt_flit [4];
  logic [3:0]        nxt_vld;
  logic [3:0]        nxt_defl;
  logic [1:0]        s2_tie;
  logic [3:0]        tgl;
  logic [3:0]        hits;
  logic [2:0]        pc;
  logic [SUM_W-1:0]  sum;

  for (genvar p = 0; p < 4; p++) begin : g_in
    assign in_f[p] = in_flit[p*FLIT_W +: FLIT_W];
  end

  // Stage 1: mid index 0/1 = S1A/S1B out0 (to S2A), 2/3 = S1A/S1B out1 (to S2B)
  ppn_arb2 #(.FLIT_W(FLIT_W), .GOLD_BIT(GOLD_BIT), .SEQ_LSB(SEQ_LSB), .SEQ_W(SEQ_W)) u_s1a (
    .flit0(in_f[0]), .flit1(in_f[1]), .vld0(in_vld[0]), .vld1(in_vld[1]),
    .defl0(1'b0), .defl1(1'b0),
    .want0(in_f[0][DIR_LSB+1]), .want1(in_f[1][DIR_LSB+1]), .tgl(tgl[0]),
    .res_flit0_c(s1_flit[0]), .res_flit1_c(s1_flit[2]),
    .res_vld0_c(s1_vld[0]), .res_vld1_c(s1_vld[2]),
    .res_defl0_c(s1_defl[0]), .res_defl1_c(s1_defl[2]), .tie_c(s1_tie[0]));

  ppn_arb2 #(.FLIT_W(FLIT_W), .GOLD_BIT(GOLD_BIT), .SEQ_LSB(SEQ_LSB), .SEQ_W(SEQ_W)) u_s1b (
    .flit0(in_f[2]), .flit1(in_f[3]), .vld0(in_vld[2]), .vld1(in_vld[3]),
    .defl0(1'b0), .defl1(1'b0),
    .want0(in_f[2][DIR_LSB+1]), .want1(in_f[3][DIR_LSB+1]), .tgl(tgl[1]),
    .res_flit0_c(s1_flit[1]), .res_flit1_c(s1_flit[3]),
    .res_vld0_c(s1_vld[1]), .res_vld1_c(s1_vld[3]),
    .res_defl0_c(s1_defl[1]), .res_defl1_c(s1_defl[3]), .tie_c(s1_tie[1]));

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_flit[i] <= '0;
        m_vld  <= '0;
        m_defl <= '0;
      end else begin
        for (int i = 0; i < 4; i++) m_flit[i] <= s1_flit[i];
        m_vld  <= s1_vld;
        m_defl <= s1_defl;
      end
    end
  end else begin : g_nopipe
    for (genvar i = 0; i < 4; i++) begin : g_m
      assign m_flit[i] = s1_flit[i];
    end
    assign m_vld  = s1_vld;
    assign m_defl = s1_defl;
  end

  // Stage 2: S2A resolves N/E (wants N on dir 00), S2B resolves S/W (wants S on dir 10)
  ppn_arb2 #(.FLIT_W(FLIT_W), .GOLD_BIT(GOLD_BIT), .SEQ_LSB(SEQ_LSB), .SEQ_W(SEQ_W)) u_s2a (
    .flit0(m_flit[0]), .flit1(m_flit[1]), .vld0(m_vld[0]), .vld1(m_vld[1]),
    .defl0(m_defl[0]), .defl1(m_defl[1]),
    .want0(m_flit[0][DIR_LSB +: 2] != 2'b00), .want1(m_flit[1][DIR_LSB +: 2] != 2'b00),
    .tgl(tgl[2]),
    .res_flit0_c(nxt_flit[0]), .res_flit1_c(nxt_flit[1]),
    .res_vld0_c(nxt_vld[0]), .res_vld1_c(nxt_vld[1]),
    .res_defl0_c(nxt_defl[0]), .res_defl1_c(nxt_defl[1]), .tie_c(s2_tie[0]));

  ppn_arb2 #(.FLIT_W(FLIT_W), .GOLD_BIT(GOLD_BIT), .SEQ_LSB(SEQ_LSB), .SEQ_W(SEQ_W)) u_s2b (
    .flit0(m_flit[2]), .flit1(m_flit[3]), .vld0(m_vld[2]), .vld1(m_vld[3]),
    .defl0(m_defl[2]), .defl1(m_defl[3]),
    .want0(m_flit[2][DIR_LSB +: 2] != 2'b10), .want1(m_flit[3][DIR_LSB +: 2] != 2'b10),
    .tgl(tgl[3]),
    .res_flit0_c(nxt_flit[2]), .res_flit1_c(nxt_flit[3]),
    .res_vld0_c(nxt_vld[2]), .res_vld1_c(nxt_vld[3]),
    .res_defl0_c(nxt_defl[2]), .res_defl1_c(nxt_defl[3]), .tie_c(s2_tie[1]));

  always_comb begin
    hits = nxt_defl & nxt_vld;
    pc   = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    sum  = SUM_W'(defl_cnt) + SUM_W'(pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl      <= '0;
      out_flit <= '0;
      out_vld  <= '0;
      out_defl <= '0;
      defl_cnt <= '0;
    end else begin
      tgl      <= tgl ^ {s2_tie, s1_tie};
      out_flit <= {nxt_flit[3], nxt_flit[2], nxt_flit[1], nxt_flit[0]};
      out_vld  <= nxt_vld;
      out_defl <= nxt_defl;
      if (cnt_clr)                   defl_cnt <= '0;
      else if (sum > SUM_W'(CNT_MAX)) defl_cnt <= CNT_MAX;
      else                           defl_cnt <= CNT_W'(sum);
    end
  end
endmodule
